// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and defaults for the two-port memory controller
package mem_ctrl_pkg;
    localparam int AW_DEF = 9;
    localparam int DW_DEF = 20;
    localparam int NREQ = 2;
    typedef enum logic {INIT, RUN} ctrl_state_t;
    typedef logic [AW_DEF-1:0] addr_t;
    typedef logic [DW_DEF-1:0] data_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, pointer moves only on a completed grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] gnt
);
    logic last;
    always_ff @(posedge clk)
        if (rst) last <= 1'b1;
        else if (ack) last <= gnt[1];
    assign gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_twoport_ctrl.sv
// mem_twoport_ctrl: init sweep, write/read arbitration and response path for mem_twoport
module mem_twoport_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          wr_valid,
    input  logic [NREQ-1:0][AW-1:0]  wr_addr,
    input  logic [NREQ-1:0][DW-1:0]  wr_data,
    output logic [NREQ-1:0]          wr_ready,
    input  logic [NREQ-1:0]          rd_valid,
    input  logic [NREQ-1:0][AW-1:0]  rd_addr,
    output logic [NREQ-1:0]          rd_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_data,
    output logic                     init_done,
    output logic [AW-1:0]            mem_ra,
    output logic [AW-1:0]            mem_wa,
    output logic                     mem_write,
    output logic [DW-1:0]            mem_d,
    input  logic [DW-1:0]            mem_q
);
    ctrl_state_t state;
    logic [AW-1:0] init_cnt;
    logic run;
    logic [1:0] wg, rg, rsp_id;
    logic hit;
    logic [DW-1:0] fwd;

    assign run = (state == RUN) && !rst;

    rr_arb2 u_warb (.clk(clk), .rst(rst), .req(wr_valid & {2{run}}), .ack(|wg), .gnt(wg));
    rr_arb2 u_rarb (.clk(clk), .rst(rst), .req(rd_valid & {2{run}}), .ack(|rg), .gnt(rg));

    always_ff @(posedge clk)
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (&init_cnt) state <= RUN;
        end

    // a same-address read/write pair returns the write data instead of the read-first old value
    always_ff @(posedge clk)
        if (rst) begin
            rsp_id <= '0;
            hit    <= 1'b0;
            fwd    <= '0;
        end else begin
            rsp_id <= rg;
            hit    <= |rg && |wg && (mem_ra == mem_wa);
            fwd    <= mem_d;
        end

    always_comb begin
        mem_write = rst ? 1'b0 : (state == INIT) ? 1'b1 : |wg;
        mem_wa    = rst ? '0 : (state == INIT) ? init_cnt : wg[1] ? wr_addr[1] : wg[0] ? wr_addr[0] : '0;
        mem_d     = rst ? '0 : (state == INIT) ? INIT_VAL : wg[1] ? wr_data[1] : wg[0] ? wr_data[0] : '0;
        mem_ra    = rg[1] ? rd_addr[1] : rg[0] ? rd_addr[0] : '0;
    end

    assign wr_ready  = wg;
    assign rd_ready  = rg;
    assign init_done = (state == RUN);
    assign rsp_valid = rsp_id;
    assign rsp_data  = |rsp_id ? (hit ? fwd : mem_q) : '0;
endmodule

// File: tb/tb_mem_twoport_ctrl.sv
// tb_mem_twoport_ctrl: randomized self-checking bench with a memory model and scoreboard
module tb_mem_twoport_ctrl;
    localparam int AW = 9;
    localparam int DW = 20;
    localparam int N = 1 << AW;

    logic clk = 0;
    logic rst = 1;
    logic [1:0] wr_valid = '0, rd_valid = '0;
    logic [1:0][AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [1:0][DW-1:0] wr_data = '0;
    logic [1:0] wr_ready, rd_ready, rsp_valid;
    logic [DW-1:0] rsp_data, mem_d, mem_q;
    logic init_done, mem_write;
    logic [AW-1:0] mem_ra, mem_wa;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] ref_mem [N];
    int checks = 0, errors = 0;
    int wlast = 1, rlast = 1;
    bit mrun = 0;
    logic [1:0] ewg, erg, exp_v = '0;
    logic [DW-1:0] exp_d = '0;

    mem_twoport_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
        .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_write(mem_write), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // read-first two-port memory
    always @(posedge clk) begin
        mem_q <= mem[mem_ra];
        if (mem_write) mem[mem_wa] <= mem_d;
    end

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic int idx(input logic [1:0] g);
        return g[1] ? 1 : 0;
    endfunction

    task automatic tick;
        int iw, ir;
        #1;
        ewg = mrun ? rr_pick(wr_valid, wlast) : 2'b00;
        erg = mrun ? rr_pick(rd_valid, rlast) : 2'b00;
        iw = idx(ewg);
        ir = idx(erg);
        checks++;
        if (wr_ready !== ewg) begin errors++; $display("FAIL wr_ready: got %b exp %b", wr_ready, ewg); end
        checks++;
        if (rd_ready !== erg) begin errors++; $display("FAIL rd_ready: got %b exp %b", rd_ready, erg); end
        checks++;
        if (init_done !== mrun) begin errors++; $display("FAIL init_done: got %b exp %b", init_done, mrun); end
        if (mrun) begin
            checks++;
            if (mem_write !== (ewg != 0)) begin errors++; $display("FAIL mem_write: got %b exp %b", mem_write, ewg != 0); end
            if (ewg != 0) begin
                checks++;
                if (mem_wa !== wr_addr[iw] || mem_d !== wr_data[iw]) begin
                    errors++; $display("FAIL mem_wa/d: got %0d/%h exp %0d/%h", mem_wa, mem_d, wr_addr[iw], wr_data[iw]);
                end
            end
            if (erg != 0) begin
                checks++;
                if (mem_ra !== rd_addr[ir]) begin errors++; $display("FAIL mem_ra: got %0d exp %0d", mem_ra, rd_addr[ir]); end
            end
        end
        exp_v = erg;
        if (erg != 0)
            exp_d = (ewg != 0 && wr_addr[iw] == rd_addr[ir]) ? wr_data[iw] : ref_mem[rd_addr[ir]];
        @(posedge clk);
        if (ewg != 0) begin ref_mem[wr_addr[iw]] = wr_data[iw]; wlast = iw; end
        if (erg != 0) rlast = ir;
        @(negedge clk);
        checks++;
        if (rsp_valid !== exp_v) begin errors++; $display("FAIL rsp_valid: got %b exp %b", rsp_valid, exp_v); end
        if (exp_v != 0) begin
            checks++;
            if (rsp_data !== exp_d) begin errors++; $display("FAIL rsp_data: got %h exp %h", rsp_data, exp_d); end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({wr_ready, rd_ready, rsp_valid, rsp_data, init_done, mem_write, mem_wa, mem_ra, mem_d} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy %b/%b rsp %b/%h done %b we %b wa %0d ra %0d d %h exp all 0",
                     wr_ready, rd_ready, rsp_valid, rsp_data, init_done, mem_write, mem_wa, mem_ra, mem_d);
        end
    endtask

    // call just after a negedge with rst high; leaves the bench in RUN
    task automatic test_init;
        rd_valid = 2'b01; rd_addr[0] = 3;
        wr_valid = 2'b10; wr_addr[1] = 9; wr_data[1] = DW'($urandom);
        rst = 0;
        for (int i = 0; i < N; i++) begin
            #1;
            checks++;
            if (mem_write !== 1'b1 || mem_wa !== AW'(i) || mem_d !== '0 || wr_ready !== 2'b00 ||
                rd_ready !== 2'b00 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL init_sweep[%0d]: got we %b wa %0d d %h rdy %b/%b done %b exp 1 %0d 0 00/00 0",
                         i, mem_write, mem_wa, mem_d, wr_ready, rd_ready, init_done, i);
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int a = 0; a < N; a++) ref_mem[a] = '0;
        wlast = 1; rlast = 1; mrun = 1; exp_v = '0;
        tick();
        wr_valid = '0; rd_valid = '0;
    endtask

    task automatic test_contention;
        wr_valid = 2'b11; wr_addr[0] = 10; wr_addr[1] = 20;
        for (int i = 0; i < 4; i++) begin
            wr_data[0] = DW'($urandom); wr_data[1] = DW'($urandom);
            #1;
            checks++;
            if (wr_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL contention_grant[%0d]: got %b exp %b", i, wr_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
        end
        wr_valid = '0;
        rd_valid = 2'b11; rd_addr[0] = 10; rd_addr[1] = 20;
        tick();
        rd_valid = rd_valid & ~erg;
        tick();
        rd_valid = '0;
    endtask

    task automatic test_write_read;
        wr_valid = 2'b01; wr_addr[0] = 5; wr_data[0] = 517;
        tick();
        wr_valid = '0;
        rd_valid = 2'b10; rd_addr[1] = 5;
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== DW'(517)) begin
            errors++; $display("FAIL write_then_read: got %b/%0d exp 10/517", rsp_valid, rsp_data);
        end
        rd_valid = '0;
    endtask

    task automatic test_forward;
        wr_valid = 2'b01; wr_addr[0] = 7; wr_data[0] = 20'h12345;
        rd_valid = 2'b01; rd_addr[0] = 7;
        tick();
        checks++;
        if (rsp_data !== 20'h12345) begin errors++; $display("FAIL forward_hit: got %h exp 12345", rsp_data); end
        rd_addr[0] = 8;
        tick();
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL forward_miss: got %h exp 0", rsp_data); end
        wr_valid = '0; rd_valid = '0;
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!wr_valid[r] && $urandom_range(1) == 1) begin
                    wr_valid[r] = 1'b1; wr_addr[r] = AW'($urandom_range(15)); wr_data[r] = DW'($urandom);
                end
                if (!rd_valid[r] && $urandom_range(1) == 1) begin
                    rd_valid[r] = 1'b1; rd_addr[r] = AW'($urandom_range(15));
                end
            end
            tick();
            wr_valid = wr_valid & ~ewg;
            rd_valid = rd_valid & ~erg;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            wr_valid = wr_valid & ~ewg;
            rd_valid = rd_valid & ~erg;
        end
    endtask

    task automatic test_mid_reset;
        wr_valid = 2'b01; wr_addr[0] = 5; wr_data[0] = 517;
        tick();
        wr_valid = '0;
        rd_valid = 2'b01; rd_addr[0] = 5;
        #1;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        rd_valid = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || mem_write !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got rsp %b we %b done %b exp 00 0 0", rsp_valid, mem_write, init_done);
        end
        mrun = 0;
        @(negedge clk);
        test_init();
        rd_valid = 2'b10; rd_addr[1] = 5;
        tick();
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL cleared_after_reset: got %h exp 0", rsp_data); end
        rd_valid = '0;
    endtask

    initial begin
        for (int a = 0; a < N; a++) mem[a] = DW'($urandom);
        test_reset();
        test_init();
        test_contention();
        test_write_read();
        test_forward();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
